// File: rtl/laser_ctrl.sv
// laser_ctrl: fires, moves and retires a single horizontal player laser.
// The laser is drawn through a shared pixel-plot port that is taken with a
// req/grant handshake.
// Optional build macro: LASER_AUTOFIRE_EN. When it is defined, fire in IDLE
// follows the space level. When it is not defined, fire needs a rising edge
// of space.
module laser_ctrl #(
  parameter int unsigned LASER_W = 5,
  parameter int unsigned START_Y = 110,
  parameter int unsigned STEP    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       space,
  input  logic       frame_tick,
  input  logic [7:0] player_x,
  input  logic       hit,
  input  logic       grant,
  output logic       req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       active
);

  typedef enum logic [2:0] {StIdle, StDraw, StFly, StErase, StMove} state_t;

  localparam logic [2:0] CntLast = 3'(LASER_W - 1);
  localparam logic [7:0] XMax    = 8'(256 - LASER_W);
  localparam logic [6:0] StartY  = 7'(START_Y);
  localparam logic [6:0] StepY   = 7'(STEP);

  localparam logic [2:0] ColEdge  = 3'b100;
  localparam logic [2:0] ColInner = 3'b101;
  localparam logic [2:0] ColBlack = 3'b000;

  state_t     state_q, state_d;
  logic [7:0] lx_q, lx_d;
  logic [6:0] ly_q, ly_d;
  logic [2:0] cnt_q, cnt_d;
  logic       space_q;
  logic       tick_pend_q, tick_pend_d;
  logic       hit_pend_q, hit_pend_d;
  logic       fire;

  logic       req_d, active_d;
  logic [7:0] x_d;
  logic [6:0] y_d;
  logic [2:0] colour_d;

`ifdef LASER_AUTOFIRE_EN
  assign fire = space;
`else
  assign fire = space & ~space_q;
`endif

  // Next-state logic: pixel walks, flight and pending-event bookkeeping.
  always_comb begin
    state_d     = state_q;
    lx_d        = lx_q;
    ly_d        = ly_q;
    cnt_d       = cnt_q;
    tick_pend_d = tick_pend_q;
    hit_pend_d  = hit_pend_q;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          lx_d        = (player_x > XMax) ? XMax : player_x;
          ly_d        = StartY;
          cnt_d       = 3'd0;
          tick_pend_d = 1'b0;
          hit_pend_d  = 1'b0;
          state_d     = StDraw;
        end
      end
      StDraw, StErase: begin
        // A tick during a walk is kept so the following move is not lost.
        tick_pend_d = tick_pend_q | frame_tick;
        hit_pend_d  = hit_pend_q | hit;
        if (grant) begin
          if (cnt_q == CntLast) begin
            cnt_d   = 3'd0;
            state_d = (state_q == StDraw) ? StFly : StMove;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StFly: begin
        hit_pend_d = hit_pend_q | hit;
        if (hit_pend_q || tick_pend_q || frame_tick) begin
          tick_pend_d = 1'b0;
          state_d     = StErase;
        end
      end
      StMove: begin
        tick_pend_d = tick_pend_q | frame_tick;
        hit_pend_d  = hit_pend_q | hit;
        if (hit_pend_q || (ly_q < StepY)) begin
          state_d = StIdle;
        end else begin
          ly_d    = ly_q - StepY;
          state_d = StDraw;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output values for the next cycle, decoded from the next-state values.
  always_comb begin
    req_d    = (state_d == StDraw) || (state_d == StErase);
    active_d = (state_d != StIdle);
    x_d      = 8'd0;
    y_d      = 7'd0;
    colour_d = ColBlack;
    if (req_d) begin
      x_d = lx_d + {5'd0, cnt_d};
      y_d = ly_d;
      if (state_d == StDraw) begin
        colour_d = ((cnt_d == 3'd0) || (cnt_d == CntLast)) ? ColEdge : ColInner;
      end
    end
  end

  // State, position and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      lx_q        <= 8'd0;
      ly_q        <= 7'd0;
      cnt_q       <= 3'd0;
      space_q     <= 1'b0;
      tick_pend_q <= 1'b0;
      hit_pend_q  <= 1'b0;
      req         <= 1'b0;
      x           <= 8'd0;
      y           <= 7'd0;
      colour      <= 3'd0;
      active      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      cnt_q       <= cnt_d;
      space_q     <= space;
      tick_pend_q <= tick_pend_d;
      hit_pend_q  <= hit_pend_d;
      req         <= req_d;
      x           <= x_d;
      y           <= y_d;
      colour      <= colour_d;
      active      <= active_d;
    end
  end

  // The strobe is the only output that depends on an input in the same cycle.
  assign plot = req & grant;

endmodule

// File: tb/tb_laser_ctrl.sv
// tb_laser_ctrl: directed and random stimulus for laser_ctrl. The outputs are
// compared every cycle against a model that keeps the pixel writes still owed
// to the plot port in a queue.
module tb_laser_ctrl;

  localparam int W  = 5;
  localparam int SY = 110;
  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       r_reset, r_space, r_tick, r_hit, r_grant;
  logic [7:0] r_px;
  logic       req, plot, active;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int n_vec = 0;
  int n_err = 0;

  laser_ctrl #(.LASER_W(W), .START_Y(SY), .STEP(ST)) dut (
    .clk        (clk),
    .reset      (r_reset),
    .space      (r_space),
    .frame_tick (r_tick),
    .player_x   (r_px),
    .hit        (r_hit),
    .grant      (r_grant),
    .req        (req),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .active     (active)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pixel writes still owed, plus flight status.
  typedef struct {
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] pc;
  } pix_t;

  pix_t wq[$];
  bit   m_busy, m_erasing, m_in_move, m_tp, m_hp, m_sp;
  int   m_x, m_y;

  task automatic push_walk(input bit erase);
    pix_t p;
    for (int i = 0; i < W; i++) begin
      p.px = 8'(m_x + i);
      p.py = 7'(m_y);
      p.pc = erase ? 3'd0 : ((i == 0 || i == W - 1) ? 3'd4 : 3'd5);
      wq.push_back(p);
    end
    m_erasing = erase;
  endtask

  task automatic model_update();
    bit fire, old_hp;
    if (r_reset) begin
      wq.delete();
      m_busy = 0; m_erasing = 0; m_in_move = 0; m_tp = 0; m_hp = 0; m_sp = 0;
      m_x = 0; m_y = 0;
      return;
    end
`ifdef LASER_AUTOFIRE_EN
    fire = r_space;
`else
    fire = r_space && !m_sp;
`endif
    if (!m_busy) begin
      if (fire) begin
        m_busy = 1; m_tp = 0; m_hp = 0;
        m_x = (r_px > 256 - W) ? 256 - W : int'(r_px);
        m_y = SY;
        push_walk(0);
      end
    end else if (m_in_move) begin
      old_hp = m_hp;
      m_tp = m_tp | r_tick;
      m_hp = m_hp | r_hit;
      m_in_move = 0;
      if (old_hp || m_y < ST) m_busy = 0;
      else begin
        m_y = m_y - ST;
        push_walk(0);
      end
    end else if (wq.size() > 0) begin
      m_tp = m_tp | r_tick;
      m_hp = m_hp | r_hit;
      if (r_grant) begin
        void'(wq.pop_front());
        if (wq.size() == 0 && m_erasing) m_in_move = 1;
      end
    end else begin
      if (m_hp || m_tp || r_tick) begin
        m_tp = 0;
        push_walk(1);
      end
      m_hp = m_hp | r_hit;
    end
    m_sp = r_space;
  endtask

  // One clock: compare on the falling edge, then advance the model.
  task automatic cycle(input bit do_chk = 1);
    logic [20:0] obs, exp;
    @(negedge clk);
    if (do_chk) begin
      if (wq.size() > 0)
        exp = {1'b1, wq[0].px, wq[0].py, wq[0].pc, r_grant, m_busy};
      else
        exp = {1'b0, 8'd0, 7'd0, 3'd0, 1'b0, m_busy};
      obs = {req, x, y, colour, plot, active};
      n_vec++;
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL cycle t=%0t {req,x,y,col,plot,act} got=%0h exp=%0h", $time, obs, exp);
      end
    end
    @(posedge clk);
    model_update();
    #1;
    r_tick = 1'b0;
    r_hit  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fire_at(input logic [7:0] px);
    r_px = px; r_space = 1'b1;
    cycle();
    r_space = 1'b0;
  endtask

  initial begin
    r_reset = 1'b1; r_space = 1'b0; r_tick = 1'b0; r_hit = 1'b0; r_grant = 1'b1;
    r_px = 8'd0;
    cycle(0);
    cycle(0);
    r_reset = 1'b0;
    chk("reset_outs", {23'd0, req, x, y, colour, plot, active}, 32'd0);

    // Fire and full draw at x 40..44.
    fire_at(8'd40);
    chk("first_x", x, 40);
    chk("first_y", y, 110);
    chk("first_col", colour, 3'b100);
    run(5);
    run(3);
    chk("fly_active", {req, active}, 2'b01);

    // One move: erase, MOVE, redraw at 108.
    r_tick = 1'b1;
    cycle();
    run(11);
    run(2);

    // Grant stall at cnt=2 during the next erase.
    r_tick = 1'b1;
    cycle();
    run(2);
    r_grant = 1'b0;
    run(3);
    chk("stall_x", x, 42);
    chk("stall_plot", plot, 1'b0);
    r_grant = 1'b1;
    run(15);

    // Space pulse while in flight is ignored.
    fire_at(8'd7);
    run(4);
    chk("ignored_fire_x", {req, active}, 2'b01);

    // Hit during DRAW: draw finishes, then erase and retire.
    r_tick = 1'b1;
    cycle();
    run(7);
    r_hit = 1'b1;
    cycle();
    run(25);
    chk("hit_retired", active, 1'b0);

    // Right-edge clamp.
    fire_at(8'd254);
    chk("clamp_x", x, 251);

    // Fly to the top of the screen.
    for (int t = 0; t < 70 && m_busy; t++) begin
      r_tick = 1'b1;
      cycle();
      run(13);
    end
    chk("top_retired", active, 1'b0);

    // Hit and tick together in FLY.
    fire_at(8'd100);
    run(8);
    r_tick = 1'b1; r_hit = 1'b1;
    cycle();
    run(15);
    chk("hit_tick_retired", active, 1'b0);

    // Space held through retirement.
    r_px = 8'd60; r_space = 1'b1;
    cycle();
    run(8);
    r_hit = 1'b1;
    cycle();
    run(20);
`ifdef LASER_AUTOFIRE_EN
    chk("held_space", active, 1'b1);
`else
    chk("held_space", active, 1'b0);
`endif
    r_space = 1'b0;
    r_reset = 1'b1;
    cycle();
    r_reset = 1'b0;

    // Reset in the middle of an erase.
    fire_at(8'd20);
    run(7);
    r_tick = 1'b1;
    cycle();
    run(2);
    r_reset = 1'b1;
    cycle();
    r_reset = 1'b0;
    chk("reset_mid_erase", {23'd0, req, x, y, colour, plot, active}, 32'd0);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      r_grant = ($urandom_range(0, 3) != 0);
      r_tick  = ($urandom_range(0, 24) == 0);
      r_hit   = ($urandom_range(0, 79) == 0);
      r_reset = ($urandom_range(0, 799) == 0);
      r_px    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) r_space = ~r_space;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
